// File: rtl/seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_pkg                                                              |
// | Shared glyph table, blank constant and scan-state type for the       |
// | multiplexed seven-segment scanner.                                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Index is the nibble value; bit0 = segment a ... bit6 = segment g.
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic [0:0] {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/hex7seg_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hex7seg_dec                                                          |
// | Combinational nibble to seven-segment glyph decoder.                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hex7seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_GLYPH[nibble_i];
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_display.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_scan_display                                                     |
// | Multiplexed hex display scanner with blanking gap, frame-aligned     |
// | value update and leading-zero suppression.                           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 2000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] in_data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_suppress,
  output logic [6:0]              data_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   seg_sel,
  output logic                    frame_ack
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [DW-1:0]         DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [BW-1:0]         BLANK_LAST = BW'(BLANK_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE    = NUM_DIGITS'(1);

  scan_state_t             state_q;
  logic [IW-1:0]           idx_q;
  logic [DW-1:0]           dwell_q;
  logic [BW-1:0]           blank_q;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic                    pending_q, pending_d;
  logic                    frame_ack_q, frame_ack_d;
  logic [6:0]              data_out_q;
  logic                    dp_out_q;
  logic [NUM_DIGITS-1:0]   seg_sel_q;

  logic                    w_commit;
  logic [3:0]              w_nibble;
  logic [6:0]              w_seg;
  logic [NUM_DIGITS-1:0]   w_zero_from;
  logic                    w_run;
  logic                    w_lz_blank;
  logic [NUM_DIGITS-1:0]   w_sel;

  // Last blank cycle after the final digit is the only point the value may change.
  assign w_commit = en && (state_q == ST_BLANK) && (idx_q == IDX_LAST) &&
                    (blank_q == BLANK_LAST);

  assign w_nibble = active_q[{idx_q, 2'b00} +: 4];
  assign w_sel    = SEL_ONE << idx_q;

  hex7seg_dec u_dec (
    .nibble_i (w_nibble),
    .seg_o    (w_seg)
  );

  // w_zero_from[i] is set when nibble i and every nibble above it are zero.
  always_comb begin
    w_zero_from = '0;
    w_run       = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_run          = w_run && (active_q[4*i +: 4] == 4'h0);
      w_zero_from[i] = w_run;
    end
  end

  assign w_lz_blank = lz_suppress && (idx_q != '0) && w_zero_from[idx_q];

  always_comb begin
    active_d    = active_q;
    active_dp_d = active_dp_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    pending_d   = pending_q;
    frame_ack_d = 1'b0;
    if (w_commit && load) begin
      active_d    = in_data;
      active_dp_d = dp_in;
      pending_d   = 1'b0;
      frame_ack_d = 1'b1;
    end else if (w_commit && pending_q) begin
      active_d    = shadow_q;
      active_dp_d = shadow_dp_q;
      pending_d   = 1'b0;
      frame_ack_d = 1'b1;
    end else if (load) begin
      shadow_d    = in_data;
      shadow_dp_d = dp_in;
      pending_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SHOW;
      idx_q       <= '0;
      dwell_q     <= '0;
      blank_q     <= '0;
      active_q    <= '0;
      active_dp_q <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      pending_q   <= 1'b0;
      frame_ack_q <= 1'b0;
      data_out_q  <= SEG_BLANK;
      dp_out_q    <= 1'b0;
      seg_sel_q   <= '0;
    end else begin
      active_q    <= active_d;
      active_dp_q <= active_dp_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      pending_q   <= pending_d;
      frame_ack_q <= frame_ack_d;
      if (!en) begin
        state_q    <= ST_SHOW;
        idx_q      <= '0;
        dwell_q    <= '0;
        blank_q    <= '0;
        data_out_q <= SEG_BLANK;
        dp_out_q   <= 1'b0;
        seg_sel_q  <= '0;
      end else begin
        case (state_q)
          ST_SHOW: begin
            seg_sel_q  <= w_sel;
            data_out_q <= w_lz_blank ? SEG_BLANK : w_seg;
            dp_out_q   <= active_dp_q[idx_q];
            if (dwell_q == DWELL_LAST) begin
              dwell_q <= '0;
              state_q <= ST_BLANK;
            end else begin
              dwell_q <= dwell_q + 1'b1;
            end
          end
          ST_BLANK: begin
            seg_sel_q  <= '0;
            data_out_q <= SEG_BLANK;
            dp_out_q   <= 1'b0;
            if (blank_q == BLANK_LAST) begin
              blank_q <= '0;
              state_q <= ST_SHOW;
              idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
              blank_q <= blank_q + 1'b1;
            end
          end
          default: state_q <= ST_SHOW;
        endcase
      end
    end
  end

  assign data_out  = data_out_q;
  assign dp_out    = dp_out_q;
  assign seg_sel   = seg_sel_q;
  assign frame_ack = frame_ack_q;

endmodule
`default_nettype wire

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 The module SHALL have parameter NUM_DIGITS, default 4, meaning digits scanned (legal 2..8).
REQ-002 The module SHALL have parameter DWELL_CYCLES, default 2000, meaning clocks each digit is lit (legal ≥2).
REQ-003 The module SHALL have parameter BLANK_CYCLES, default 16, meaning anti-ghosting gap between digits (legal ≥1).
REQ-004 The module SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 en  input  1  scan enable; low forces display dark.
REQ-007 load  input  1  single-cycle request to update the displayed value.
REQ-008 in_data  input  4*NUM_DIGITS  hex nibbles; nibble 0 is the rightmost digit.
REQ-009 dp_in  input  NUM_DIGITS  decimal-point enables, bit i for digit i.
REQ-010 lz_suppress  input  1  leading-zero blanking enable.
REQ-011 data_out  output  7  segments a..g, bit0=a, active-high, registered.
REQ-012 dp_out  output  1  decimal-point segment, registered.
REQ-013 seg_sel  output  NUM_DIGITS  one-hot digit select, active-high, registered.
REQ-014 frame_ack  output  1  one-cycle pulse when a pending value is committed.

Function
REQ-015 The scanner SHALL be a two-state FSM: SHOW (seg_sel one-hot on digit idx, segments driven for DWELL_CYCLES clocks) -> BLANK (seg_sel=0, data_out=0, dp_out=0 for BLANK_CYCLES clocks) -> SHOW on idx+1.
REQ-016 idx SHALL wrap NUM_DIGITS-1 -> 0; frame period = NUM_DIGITS*(DWELL_CYCLES+BLANK_CYCLES) clocks.
REQ-017 load=1 SHALL capture in_data/dp_in into a shadow register and set pending; a later load before commit SHALL overwrite the shadow (latest wins).
REQ-018 Commit SHALL occur in the last BLANK cycle of idx NUM_DIGITS-1 (frame boundary): shadow -> active, pending cleared, frame_ack=1 next cycle; displayed value never changes mid-frame.
REQ-019 load coincident with the commit cycle SHALL commit that cycle's in_data/dp_in directly, pending cleared, frame_ack pulsed.
REQ-020 data_out, dp_out and seg_sel SHALL change on the same clock edge (no one-cycle skew between select and segment data).
REQ-021 Decoding SHALL map nibbles 0-F to standard hex glyphs (b, d lower-case).
REQ-022 With lz_suppress=1, digit i>0 SHALL be blanked (data_out=0, dp_out still from dp) when it and all higher active nibbles are 0; digit 0 SHALL always display.
REQ-023 Dwell/blank counters SHALL be sized clog2 of their parameter and never overflow.
REQ-024 en=0 SHALL drive seg_sel=0, data_out=0, dp_out=0, hold FSM at SHOW/idx 0/count 0; active, shadow and pending SHALL be retained, and commit suspended.
REQ-025 en rising SHALL start SHOW on digit 0 on the next cycle; a held pending commits at the first subsequent frame boundary.

Reset
REQ-026 rst=1 SHALL set seg_sel=0, data_out=0, dp_out=0, frame_ack=0, active=0, shadow=0, pending=0, FSM SHOW/idx 0/count 0; rst overrides load and en.
REQ-027 rst asserted mid-frame SHALL discard any pending value; first lit digit after release (en=1) is digit 0 showing "0".

Structure
REQ-028 A shared package seg_pkg SHALL hold the segment-glyph constant table, SEG_BLANK constant and the scan-state enum.
REQ-029 Decoding SHALL reside in one combinational sub-module hex7seg_dec (4-bit nibble in, 7-bit segments out), instantiated once on the muxed nibble.

Verification (NUM_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=2)
REQ-030 Reset then en=1, load in_data=16'h1234 -> after first frame boundary frame_ack pulse; next frame seg_sel 0001/0010/0100/1000 shows 4,3,2,1, each 4 cycles, separated by 2 cycles of seg_sel=0.
REQ-031 load 16'hABCD mid-frame then 16'h0F0F before boundary -> exactly one frame_ack; next frame shows F,0,F,0; ABCD never appears.
REQ-032 lz_suppress=1, value 16'h0050 -> digits 3,2 dark, digit1 "5", digit0 "0"; value 16'h0000 -> only digit0 "0".
REQ-033 load asserted exactly on commit cycle with 16'h8888 -> same-cycle commit, frame_ack next cycle, next frame shows 8888.
REQ-034 en dropped mid-SHOW of digit 2 -> next cycle all outputs 0; en restored -> digit 0 lit next cycle, value unchanged.
REQ-035 rst pulsed mid-frame with pending load -> outputs 0, no frame_ack; after release digit 0 shows "0".
